// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, default framing, line levels.
// Used by both the transmitter and the receiver side.
package uart_pkg;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t ST_IDLE   = 3'd0;
  localparam uart_state_t ST_START  = 3'd1;
  localparam uart_state_t ST_DATA   = 3'd2;
  localparam uart_state_t ST_PARITY = 3'd3;
  localparam uart_state_t ST_STOP   = 3'd4;

  localparam int unsigned UART_CLKS_PER_BIT = 16;
  localparam int unsigned UART_DATA_BITS    = 8;
  localparam int unsigned UART_STOP_BITS    = 1;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled,
// flags the last cycle of each period on wrap.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic wrap
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign wrap = enable && (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= wrap ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, LSB-first data, optional parity, 1-2 stop bits.
// tx_out is registered and always reflects the state being held.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = UART_DATA_BITS,
  parameter int unsigned PARITY_EN    = 1,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = UART_STOP_BITS
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic       ODD       = 1'(PARITY_ODD);

  uart_state_t          state;
  logic [DATA_BITS-1:0] shreg;
  logic [2:0]           bit_idx;
  logic                 stop_idx;
  logic                 par_q;
  logic                 tx_q;
  logic                 wrap;
  logic                 accept;
  logic                 last_stop;

  assign accept    = (state == ST_IDLE) && tx_valid;
  assign last_stop = (stop_idx == LAST_STOP);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (accept),
    .enable (state != ST_IDLE),
    .wrap   (wrap)
  );

  // Parity is captured at accept since the shift register is consumed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      par_q    <= 1'b0;
      tx_q     <= LINE_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            shreg    <= tx_data;
            par_q    <= (^tx_data) ^ ODD;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            tx_q     <= LINE_START;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (wrap) begin
            tx_q  <= shreg[0];
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (wrap) begin
            if (bit_idx == LAST_BIT) begin
              if (PARITY_EN != 0) begin
                tx_q  <= par_q;
                state <= ST_PARITY;
              end else begin
                tx_q  <= LINE_IDLE;
                state <= ST_STOP;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= shreg >> 1;
              tx_q    <= shreg[1];
            end
          end
        end
        ST_PARITY: begin
          if (wrap) begin
            tx_q  <= LINE_IDLE;
            state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (wrap) begin
            if (last_stop) state <= ST_IDLE;
            else stop_idx <= stop_idx + 1'b1;
          end
        end
        default: begin
          tx_q  <= LINE_IDLE;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_out   = tx_q;
  assign tx_ready = (state == ST_IDLE);
  assign tx_busy  = (state != ST_IDLE);
  assign tx_done  = (state == ST_STOP) && wrap && last_stop;

endmodule
